ex: RTL and testbench

Execute stage of the five-stage MIPS pipeline: takes decoded operands from the ID/EX register, computes the ALU result, and presents result/write-address/write-enable to the EX/MEM register, and through it to the memory-access stage. Single-cycle ops are purely combinational. DIV/DIVU run on an iterative radix-2 divider that holds the pipeline through `stallreq_o` until the quotient and remainder are ready.

---
 rtl/ex_pkg.sv | 37 +++
 rtl/ex_div.sv | 98 +++++++++
 rtl/ex.sv | 70 +++++++
 tb/tb_ex.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared widths, ALU opcodes and divider FSM states for the execute stage.
package ex_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;

    localparam logic [ALU_OP_W-1:0] EXE_NOP  = 8'h00;
    localparam logic [ALU_OP_W-1:0] EXE_SRL  = 8'h02;
    localparam logic [ALU_OP_W-1:0] EXE_SRA  = 8'h03;
    localparam logic [ALU_OP_W-1:0] EXE_DIV  = 8'h1A;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU = 8'h1B;
    localparam logic [ALU_OP_W-1:0] EXE_ADD  = 8'h20;
    localparam logic [ALU_OP_W-1:0] EXE_SUB  = 8'h22;
    localparam logic [ALU_OP_W-1:0] EXE_AND  = 8'h24;
    localparam logic [ALU_OP_W-1:0] EXE_OR   = 8'h25;
    localparam logic [ALU_OP_W-1:0] EXE_XOR  = 8'h26;
    localparam logic [ALU_OP_W-1:0] EXE_NOR  = 8'h27;
    localparam logic [ALU_OP_W-1:0] EXE_SLT  = 8'h2A;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU = 8'h2B;
    localparam logic [ALU_OP_W-1:0] EXE_LUI  = 8'h5C;
    localparam logic [ALU_OP_W-1:0] EXE_SLL  = 8'h7C;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] DIV_LAST_STEP = 6'd31;

    function automatic logic [REG_DATA_W-1:0] magnitude(input logic [REG_DATA_W-1:0] x,
                                                        input logic is_signed);
        return (is_signed && x[REG_DATA_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider: 32 steps after the start cycle, result held one cycle in DONE.
// Divide-by-zero skips straight to DONE; annul_i returns the FSM to IDLE on the next edge.
module ex_div
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [REG_DATA_W-1:0] opdata1_i,
    input  logic [REG_DATA_W-1:0] opdata2_i,
    output logic [63:0]           result_o,
    output logic                  ready_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] rq_q, rq_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic [33:0] shifted;
    logic [32:0] diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rq_d    = rq_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        // Partial remainder shifted left with the next dividend bit brought in.
        shifted = rq_q[64:31];
        diff    = shifted[32:0] - {1'b0, dvsr_q};

        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    if (opdata2_i == '0) begin
                        rq_d    = {1'b0, opdata1_i, 32'hFFFF_FFFF};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else begin
                        rq_d    = {33'd0, magnitude(opdata1_i, signed_i)};
                        dvsr_d  = magnitude(opdata2_i, signed_i);
                        qneg_d  = signed_i && (opdata1_i[31] ^ opdata2_i[31]);
                        rneg_d  = signed_i && opdata1_i[31];
                        cnt_d   = '0;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (shifted >= {2'b00, dvsr_q}) begin
                    rq_d = {diff, rq_q[30:0], 1'b1};
                end else begin
                    rq_d = {shifted[32:0], rq_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DIV_LAST_STEP) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (annul_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rq_q    <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rq_q    <= rq_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign result_o[63:32] = rneg_q ? -rq_q[63:32] : rq_q[63:32];
    assign result_o[31:0]  = qneg_q ? -rq_q[31:0]  : rq_q[31:0];
    assign ready_o         = (state_q == DIV_DONE);

endmodule

// File: rtl/ex.sv
// MIPS execute stage: combinational ALU with zero latency; DIV/DIVU result in cycle 33 (cycle 1 for /0).
// Holds the upstream pipeline via stallreq_o while a division is in flight.
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [REG_DATA_W-1:0] reg1_i,
    input  logic [REG_DATA_W-1:0] reg2_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  we_i,
    input  logic                  annul_i,
    output logic [REG_DATA_W-1:0] result_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic [REG_DATA_W-1:0] hi_o,
    output logic [REG_DATA_W-1:0] lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o
);

    logic                  is_div;
    logic                  div_ready;
    logic [63:0]           div_result;
    logic [REG_DATA_W-1:0] alu_res;

    assign is_div = (aluop_i == EXE_DIV) || (aluop_i == EXE_DIVU);

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            EXE_ADD:  alu_res = reg1_i + reg2_i;
            EXE_SUB:  alu_res = reg1_i - reg2_i;
            EXE_AND:  alu_res = reg1_i & reg2_i;
            EXE_OR:   alu_res = reg1_i | reg2_i;
            EXE_XOR:  alu_res = reg1_i ^ reg2_i;
            EXE_NOR:  alu_res = ~(reg1_i | reg2_i);
            EXE_SLT:  alu_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU: alu_res = {31'd0, reg1_i < reg2_i};
            EXE_SLL:  alu_res = reg1_i << reg2_i[4:0];
            EXE_SRL:  alu_res = reg1_i >> reg2_i[4:0];
            EXE_SRA:  alu_res = $signed(reg1_i) >>> reg2_i[4:0];
            EXE_LUI:  alu_res = {reg2_i[15:0], 16'h0000};
            default:  alu_res = '0;
        endcase
    end

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_div && !annul_i),
        .signed_i  (aluop_i == EXE_DIV),
        .annul_i   (annul_i),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .result_o  (div_result),
        .ready_o   (div_ready)
    );

    // A flush wins over both the stall and the HI/LO write in the same cycle.
    assign whilo_o    = !rst && div_ready && !annul_i;
    assign stallreq_o = !rst && is_div && !annul_i && !div_ready;
    assign result_o   = rst ? '0 : alu_res;
    assign waddr_o    = rst ? '0 : waddr_i;
    assign we_o       = rst ? 1'b0 : we_i;
    assign hi_o       = whilo_o ? div_result[63:32] : '0;
    assign lo_o       = whilo_o ? div_result[31:0]  : '0;

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for ex: stimulus queues expectations, a negedge monitor pops and compares.
module tb_ex;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] hi_o, lo_o;
    logic        whilo_o;
    logic        stallreq_o;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .waddr_i    (waddr_i),
        .we_i       (we_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .waddr_o    (waddr_o),
        .we_o       (we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        we;
        logic [4:0]  wa;
    } alu_exp_t;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        int          stalls;
        logic        we;
        logic [4:0]  wa;
    } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_run = 0;
    logic alu_vld = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: ALU results whenever the bench marks an op valid, divide results on whilo_o.
    initial begin
        alu_exp_t ae;
        div_exp_t de;
        forever begin
            @(negedge clk);
            if (alu_vld) begin
                if (alu_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL alu_unexpected: got result %h expected no output", result_o);
                end else begin
                    ae = alu_q.pop_front();
                    check({ae.name, ".result"}, result_o, ae.res);
                    check({ae.name, ".we"}, 32'(we_o), 32'(ae.we));
                    check({ae.name, ".waddr"}, 32'(waddr_o), 32'(ae.wa));
                end
            end
            if (whilo_o) begin
                if (div_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL whilo_unexpected: got whilo 1 lo %h hi %h expected 0", lo_o, hi_o);
                end else begin
                    de = div_q.pop_front();
                    check({de.name, ".lo"}, lo_o, de.lo);
                    check({de.name, ".hi"}, hi_o, de.hi);
                    check({de.name, ".stalls"}, 32'(stall_run), 32'(de.stalls));
                    check({de.name, ".result"}, result_o, 32'd0);
                    check({de.name, ".we"}, 32'(we_o), 32'(de.we));
                    check({de.name, ".waddr"}, 32'(waddr_o), 32'(de.wa));
                end
            end
            if (stallreq_o) stall_run++;
            else            stall_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic alu(input string nm, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] wa,
                       input logic [31:0] exp);
        alu_exp_t e;
        @(posedge clk); #1;
        aluop_i = op; reg1_i = a; reg2_i = b; we_i = we; waddr_i = wa; alu_vld = 1'b1;
        e.name = nm; e.res = exp; e.we = we; e.wa = wa;
        alu_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        aluop_i = EXE_NOP; reg1_i = '0; reg2_i = '0; we_i = 1'b0; waddr_i = '0; alu_vld = 1'b0;
    endtask

    task automatic do_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int stalls);
        div_exp_t e;
        bit done;
        @(posedge clk); #1;
        alu_vld = 1'b0;
        aluop_i = op; reg1_i = a; reg2_i = b; we_i = 1'b1; waddr_i = wa;
        e.name = nm; e.lo = exp_lo; e.hi = exp_hi; e.stalls = stalls; e.we = 1'b1; e.wa = wa;
        div_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stallreq_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s.timeout: got stall beyond 60 cycles expected %0d", nm, stalls);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".result"}, result_o, 32'd0);
        check({nm, ".waddr"}, 32'(waddr_o), 32'd0);
        check({nm, ".we"}, 32'(we_o), 32'd0);
        check({nm, ".hi"}, hi_o, 32'd0);
        check({nm, ".lo"}, lo_o, 32'd0);
        check({nm, ".whilo"}, 32'(whilo_o), 32'd0);
        check({nm, ".stall"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; annul_i = 1'b0;
        aluop_i = EXE_DIVU; reg1_i = 32'd10; reg2_i = 32'd3; we_i = 1'b1; waddr_i = 5'd5;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0; aluop_i = EXE_NOP; we_i = 1'b0; waddr_i = '0;

        alu("add_wrap", EXE_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 5'd1,  32'h8000_0000);
        alu("sub",      EXE_SUB,  32'd5,         32'd7,         1'b1, 5'd2,  32'hFFFF_FFFE);
        alu("and",      EXE_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 5'd3,  32'h00F0_1234);
        alu("or",       EXE_OR,   32'h0000_F000, 32'h1234_0000, 1'b1, 5'd4,  32'h1234_F000);
        alu("xor",      EXE_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 5'd5,  32'hF0F0_0F0F);
        alu("nor",      EXE_NOR,  32'h0F0F_0000, 32'h0000_00FF, 1'b1, 5'd6,  32'hF0F0_FF00);
        alu("slt_neg",  EXE_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd7,  32'd1);
        alu("sltu_lt",  EXE_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd8,  32'd1);
        alu("sltu_ge",  EXE_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd9,  32'd0);
        alu("sll_31",   EXE_SLL,  32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd10, 32'h8000_0000);
        alu("srl_4",    EXE_SRL,  32'h8000_0000, 32'h0000_0004, 1'b1, 5'd11, 32'h0800_0000);
        alu("sra_4",    EXE_SRA,  32'h8000_0000, 32'h0000_0004, 1'b1, 5'd12, 32'hF800_0000);
        alu("lui",      EXE_LUI,  32'h0000_0000, 32'hABCD_1234, 1'b1, 5'd13, 32'h1234_0000);
        alu("unknown",  8'hFF,    32'h1111_1111, 32'h2222_2222, 1'b1, 5'd14, 32'h0000_0000);
        alu("add_nowe", EXE_ADD,  32'd3,         32'd4,         1'b0, 5'd17, 32'd7);
        idle();

        do_div("divu_100_7", EXE_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 32'd2, 33);
        idle();
        @(negedge clk);
        check("whilo_one_cycle", 32'(whilo_o), 32'd0);

        do_div("div_m7_2",    EXE_DIV,  32'hFFFF_FFF9, 32'd2,        5'd21, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_div("div_min_m1",  EXE_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 32'h0000_0000, 33);
        do_div("div_5_0",     EXE_DIV,  32'd5,         32'd0,        5'd23, 32'hFFFF_FFFF, 32'd5,         1);
        do_div("divu_max_2",  EXE_DIVU, 32'hFFFF_FFFF, 32'd2,        5'd24, 32'h7FFF_FFFF, 32'd1,         33);
        idle();

        // Flush a division in its tenth BUSY cycle.
        @(posedge clk); #1;
        aluop_i = EXE_DIVU; reg1_i = 32'd100; reg2_i = 32'd7; we_i = 1'b1; waddr_i = 5'd25;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        annul_i = 1'b1;
        @(negedge clk);
        check("annul.stall", 32'(stallreq_o), 32'd0);
        check("annul.whilo", 32'(whilo_o), 32'd0);
        @(posedge clk); #1;
        annul_i = 1'b0; aluop_i = EXE_NOP; we_i = 1'b0;
        @(negedge clk);
        check("annul.after_stall", 32'(stallreq_o), 32'd0);
        do_div("divu_after_annul", EXE_DIVU, 32'd200, 32'd9, 5'd26, 32'd22, 32'd2, 33);

        // Reset in the middle of a division, then back-to-back divides.
        @(posedge clk); #1;
        aluop_i = EXE_DIVU; reg1_i = 32'd100; reg2_i = 32'd7; we_i = 1'b1; waddr_i = 5'd27;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0; aluop_i = EXE_NOP; we_i = 1'b0;
        do_div("divu_9_3", EXE_DIVU, 32'd9, 32'd3, 5'd28, 32'd3, 32'd0, 33);
        do_div("divu_8_3", EXE_DIVU, 32'd8, 32'd3, 5'd29, 32'd2, 32'd2, 33);
        idle();
        repeat (3) @(negedge clk);

        check("alu_q_drained", 32'(alu_q.size()), 32'd0);
        check("div_q_drained", 32'(div_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
